// File: rtl/sprite_row_fetch_arbiter_pkg.sv
// Shared constants and types for the sprite row fetch arbiter.
// The derived widths size the lane, column and row fields of the fetch path.
package sprite_pkg;

    localparam int NUM_REQ = 5;
    localparam int ROW_W   = 64;
    localparam int ROWS    = 64;
    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 24;

    localparam int LANE_W    = $clog2(NUM_REQ);
    localparam int COL_W     = $clog2(ROW_W);
    localparam int ROW_IDX_W = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} fetch_state_t;

    typedef enum logic [2:0] {GREEN, RED, YELLOW, BLUE, ORANGE} lane_t;

endpackage

// File: rtl/sprite_row_fetch_arbiter_rr.sv
// Combinational round-robin search: the first requester at or above ptr,
// wrapping upward, wins; returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    int cand;

    // Scan farthest-first so the candidate closest to ptr is written last and wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sprite_row_fetch_arbiter.sv
// Grants note-lane renderers round-robin access to the shared sprite RAM and
// streams one 64-pixel row per grant, tagging RAM data with lane and column.
module sprite_row_fetch_arbiter
    import sprite_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0][ROW_IDX_W-1:0]   req_row,
    output logic [NUM_REQ-1:0]                  ack,
    output logic [NUM_REQ-1:0]                  done,
    output logic [ADDR_W-1:0]                   rom_addr,
    input  logic [DATA_W-1:0]                   rom_data,
    output logic                                pix_valid,
    output logic [DATA_W-1:0]                   pix_data,
    output logic [LANE_W-1:0]                   pix_lane,
    output logic [COL_W-1:0]                    pix_col,
    output logic                                busy
);

    fetch_state_t          state;
    logic [LANE_W-1:0]     rr_ptr;
    logic [LANE_W-1:0]     lane;
    logic [ROW_IDX_W-1:0]  row;
    logic [COL_W-1:0]      col;

    logic [NUM_REQ-1:0]    gnt;
    logic [LANE_W-1:0]     gnt_idx;
    logic [LANE_W-1:0]     next_ptr;
    logic                  burst_vld;
    logic                  pix_vld_q;
    logic [LANE_W-1:0]     pix_lane_q;
    logic [COL_W-1:0]      pix_col_q;
    logic [NUM_REQ-1:0]    lane_hot;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(LANE_W)) u_rr (
        .req (req),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign next_ptr = (gnt_idx == LANE_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            lane   <= '0;
            row    <= '0;
            col    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        lane   <= gnt_idx;
                        row    <= req_row[gnt_idx];
                        col    <= '0;
                        rr_ptr <= next_ptr;
                        state  <= BURST;
                    end
                end
                BURST: begin
                    if (col == COL_W'(ROW_W - 1)) state <= DRAIN;
                    else                          col   <= col + 1'b1;
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // One-stage tag pipeline matching the RAM's registered read.
    assign burst_vld = (state == BURST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_vld_q  <= 1'b0;
            pix_lane_q <= '0;
            pix_col_q  <= '0;
        end else begin
            pix_vld_q <= burst_vld;
            if (burst_vld) begin
                pix_lane_q <= lane;
                pix_col_q  <= col;
            end
        end
    end

    // Address comes straight from row/col, so it holds its last value outside BURST.
    assign rom_addr  = ADDR_W'({row, col});

    assign lane_hot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << lane;
    assign ack       = (burst_vld && col == '0) ? lane_hot : '0;
    assign done      = (state == DRAIN) ? lane_hot : '0;
    assign busy      = (state != IDLE);

    assign pix_valid = pix_vld_q;
    assign pix_data  = pix_vld_q ? rom_data : '0;
    assign pix_lane  = pix_lane_q;
    assign pix_col   = pix_col_q;

endmodule

// File: tb/tb_sprite_row_fetch_arbiter.sv
// Directed bench for sprite_row_fetch_arbiter with a 1-cycle RAM model
// returning 24'hA00000 | addr.
module tb_sprite_row_fetch_arbiter;
    import sprite_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0][ROW_IDX_W-1:0] req_row;
    logic [NUM_REQ-1:0]                ack, done;
    logic [ADDR_W-1:0]                 rom_addr;
    logic [DATA_W-1:0]                 rom_data;
    logic                              pix_valid, busy;
    logic [DATA_W-1:0]                 pix_data;
    logic [LANE_W-1:0]                 pix_lane;
    logic [COL_W-1:0]                  pix_col;

    int nchk = 0, nerr = 0;
    int cyc_cnt = 0;

    typedef struct {
        int         k;
        logic [4:0] ack;
        logic [4:0] done;
        logic       pv;
        int         addr;
        logic       busy;
    } vec_t;
    vec_t tbl[6];

    sprite_row_fetch_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_row(req_row), .ack(ack), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_lane(pix_lane), .pix_col(pix_col), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= 24'hA00000 | DATA_W'(rom_addr);
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"},  64'(ack), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_pv"},   64'(pix_valid), 0);
        check({tag, "_data"}, 64'(pix_data), 0);
        check({tag, "_lane"}, 64'(pix_lane), 0);
        check({tag, "_col"},  64'(pix_col), 0);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_addr"}, 64'(rom_addr), 0);
    endtask

    task automatic wait_ack(input int budget, output int lane, output int cyc);
        lane = -1;
        cyc  = cyc_cnt;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ack != '0) begin
                for (int j = 0; j < NUM_REQ; j++) if (ack[j]) lane = j;
                cyc = cyc_cnt;
                return;
            end
        end
        check("ack_timeout", 1, 0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            step();
        end
        check("idle_timeout", 1, 0);
    endtask

    initial begin
        int ti, lane, cyc, prev_cyc, nvalid, ndone, nack;
        int exp_rr[6];

        tbl[0] = '{k: 1,  ack: 5'b00100, done: 5'b00000, pv: 1'b0, addr: 640, busy: 1'b1};
        tbl[1] = '{k: 2,  ack: 5'b00000, done: 5'b00000, pv: 1'b1, addr: 641, busy: 1'b1};
        tbl[2] = '{k: 33, ack: 5'b00000, done: 5'b00000, pv: 1'b1, addr: 672, busy: 1'b1};
        tbl[3] = '{k: 64, ack: 5'b00000, done: 5'b00000, pv: 1'b1, addr: 703, busy: 1'b1};
        tbl[4] = '{k: 65, ack: 5'b00000, done: 5'b00100, pv: 1'b1, addr: 703, busy: 1'b1};
        tbl[5] = '{k: 66, ack: 5'b00000, done: 5'b00000, pv: 1'b0, addr: 703, busy: 1'b0};
        exp_rr = '{0, 1, 2, 3, 4, 0};

        // Reset state
        rst = 1'b1; req = '0; req_row = '0;
        @(negedge clk); @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        step();

        // Single request: lane 2, row 10
        req[2] = 1'b1; req_row[2] = 6'd10;
        ti = 0;
        for (int k = 1; k <= 66; k++) begin
            step();
            if (k == 1) req = '0;
            if (k <= 64) check("sr_addr", 64'(rom_addr), 64'(640 + k - 1));
            if (k >= 2 && k <= 65) begin
                check("sr_col",  64'(pix_col), 64'(k - 2));
                check("sr_lane", 64'(pix_lane), 2);
            end
            if (ti < 6 && tbl[ti].k == k) begin
                check("sr_tbl_ack",  64'(ack),       64'(tbl[ti].ack));
                check("sr_tbl_done", 64'(done),      64'(tbl[ti].done));
                check("sr_tbl_pv",   64'(pix_valid), 64'(tbl[ti].pv));
                check("sr_tbl_addr", 64'(rom_addr),  64'(tbl[ti].addr));
                check("sr_tbl_busy", 64'(busy),      64'(tbl[ti].busy));
                ti++;
            end else if (k >= 2 && k <= 65) begin
                check("sr_pv", 64'(pix_valid), 1);
            end
        end

        // Data alignment: lane 0, row 63
        req[0] = 1'b1; req_row[0] = 6'd63;
        wait_ack(10, lane, cyc);
        check("da_lane", 64'(lane), 0);
        req = '0;
        nvalid = 0;
        for (int k = 0; k < 70; k++) begin
            step();
            if (pix_valid) begin
                nvalid++;
                check("da_data", 64'(pix_data), 64'(24'hA00000 | (4032 + int'(pix_col))));
            end
        end
        check("da_count", 64'(nvalid), 64);

        // Request drop right after grant
        req[4] = 1'b1; req_row[4] = 6'd5;
        wait_ack(10, lane, cyc);
        check("drop_lane", 64'(lane), 4);
        req = '0;
        nvalid = 0; ndone = 0; nack = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (pix_valid && pix_lane == 3'd4) nvalid++;
            if (done[4]) ndone++;
            if (ack != '0) nack++;
        end
        check("drop_pix", 64'(nvalid), 64);
        check("drop_done", 64'(ndone), 1);
        check("drop_noack", 64'(nack), 0);

        // Round-robin from a fresh reset, then fairness with lanes 1 and 3
        rst = 1'b1; step(); rst = 1'b0;
        req = '1;
        for (int i = 0; i < NUM_REQ; i++) req_row[i] = ROW_IDX_W'(i + 1);
        prev_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            wait_ack(200, lane, cyc);
            check("rr_lane", 64'(lane), 64'(exp_rr[i]));
            if (i > 0) check("rr_spacing", 64'(cyc - prev_cyc), 66);
            prev_cyc = cyc;
        end
        req = 5'b01010;
        wait_ack(200, lane, cyc);
        check("fair_first", 64'(lane), 1);
        wait_ack(200, lane, cyc);
        check("fair_second", 64'(lane), 3);
        req = '0;
        wait_idle(200);

        // Reset mid-burst on lane 1
        req[1] = 1'b1; req_row[1] = 6'd3;
        wait_ack(10, lane, cyc);
        check("mr_lane", 64'(lane), 1);
        req = '0;
        for (int k = 2; k <= 20; k++) step();
        rst = 1'b1;
        #1;
        check_zero("mr_rst_a");
        step();
        check_zero("mr_rst_b");
        req = '1;
        rst = 1'b0;
        ndone = 0; nvalid = 0; lane = -1;
        for (int k = 0; k < 10 && lane < 0; k++) begin
            step();
            if (done != '0) ndone++;
            if (pix_valid) nvalid++;
            if (ack != '0) for (int j = 0; j < NUM_REQ; j++) if (ack[j]) lane = j;
        end
        check("mr_first_grant", 64'(lane), 0);
        check("mr_no_done", 64'(ndone), 0);
        check("mr_no_valid", 64'(nvalid), 0);
        req = '0;
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
